// File: rtl/wb_arbiter.sv
// Writeback/completion arbiter: NB_SRC per-source result FIFOs shared round-robin
// onto NB_WB registered writeback and completion ports.
module wb_arbiter #(
   parameter int NB_SRC = 4,
   parameter int NB_WB  = 2,
   parameter int DEPTH  = 2,
   parameter int DATA_W = 64,
   parameter int ID_W   = 6
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush_i,
   input  logic [NB_SRC-1:0]        src_valid_i,
   output logic [NB_SRC-1:0]        src_ready_o,
   input  logic [NB_SRC*ID_W-1:0]   src_id_i,
   input  logic [NB_SRC-1:0]        src_we_i,
   input  logic [NB_SRC*DATA_W-1:0] src_data_i,
   output logic [NB_WB-1:0]         wb_valid_o,
   output logic [NB_WB-1:0]         wb_we_o,
   output logic [NB_WB*ID_W-1:0]    wb_id_o,
   output logic [NB_WB*DATA_W-1:0]  wb_data_o,
   output logic [NB_WB-1:0]         compl_valid_o,
   output logic [NB_WB*ID_W-1:0]    compl_id_o,
   output logic                     err_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int RR_W  = $clog2(NB_SRC);

   logic [ID_W-1:0]         mem_id_r   [NB_SRC][DEPTH];
   logic                    mem_we_r   [NB_SRC][DEPTH];
   logic [DATA_W-1:0]       mem_data_r [NB_SRC][DEPTH];
   logic [PTR_W-1:0]        rd_ptr_r   [NB_SRC];
   logic [PTR_W-1:0]        wr_ptr_r   [NB_SRC];
   logic [CNT_W-1:0]        count_r    [NB_SRC];
   logic [RR_W-1:0]         rr_ptr_r;
   logic                    err_r;
   logic [NB_WB-1:0]        wb_valid_r;
   logic [NB_WB-1:0]        wb_we_r;
   logic [NB_WB*ID_W-1:0]   wb_id_r;
   logic [NB_WB*DATA_W-1:0] wb_data_r;

   logic [NB_SRC-1:0]       ready_s;
   logic [NB_SRC-1:0]       push_s;
   logic [NB_SRC-1:0]       grant_s;
   int                      rank_s     [NB_SRC];
   logic [NB_WB-1:0]        port_vld_s;
   logic [RR_W-1:0]         port_src_s [NB_WB];
   logic [RR_W-1:0]         rr_next_s;

   // Ready comes from registered occupancy only, so a same-cycle pop never frees a full FIFO
   always_comb begin
      for (int s = 0; s < NB_SRC; s++) begin
         ready_s[s] = (count_r[s] != CNT_W'(DEPTH));
         push_s[s]  = src_valid_i[s] & ready_s[s];
      end
   end

   assign src_ready_o = ready_s;

   // Round-robin scan from rr_ptr: first NB_WB non-empty heads, k-th winner drives port k
   always_comb begin
      int              nsel;
      logic            take;
      logic [RR_W-1:0] idx;
      logic [RR_W-1:0] last;
      nsel    = 0;
      take    = 1'b0;
      idx     = rr_ptr_r;
      last    = rr_ptr_r;
      grant_s = '0;
      for (int s = 0; s < NB_SRC; s++) begin
         rank_s[s] = 0;
      end
      for (int i = 0; i < NB_SRC; i++) begin
         idx            = RR_W'((int'(rr_ptr_r) + i) % NB_SRC);
         take           = (count_r[idx] != '0) && (nsel < NB_WB);
         grant_s[idx]   = take;
         rank_s[idx]    = nsel;
         last           = take ? idx : last;
         nsel           = nsel + (take ? 1 : 0);
      end
      for (int k = 0; k < NB_WB; k++) begin
         port_vld_s[k] = 1'b0;
         port_src_s[k] = '0;
         for (int s = 0; s < NB_SRC; s++) begin
            port_vld_s[k] = port_vld_s[k] | (grant_s[s] && (rank_s[s] == k));
            port_src_s[k] = (grant_s[s] && (rank_s[s] == k)) ? RR_W'(s) : port_src_s[k];
         end
      end
      rr_next_s = (nsel > 0) ? RR_W'((int'(last) + 1) % NB_SRC) : rr_ptr_r;
   end

   // FIFO pointers/occupancy, round-robin pointer and sticky overflow flag
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < NB_SRC; s++) begin
            rd_ptr_r[s] <= '0;
            wr_ptr_r[s] <= '0;
            count_r[s]  <= '0;
         end
         rr_ptr_r <= '0;
         err_r    <= 1'b0;
      end else begin
         err_r <= err_r | (|(src_valid_i & ~ready_s));
         if (flush_i) begin
            for (int s = 0; s < NB_SRC; s++) begin
               rd_ptr_r[s] <= '0;
               wr_ptr_r[s] <= '0;
               count_r[s]  <= '0;
            end
         end else begin
            rr_ptr_r <= rr_next_s;
            for (int s = 0; s < NB_SRC; s++) begin
               if (push_s[s]) wr_ptr_r[s] <= wr_ptr_r[s] + PTR_W'(1);
               if (grant_s[s]) rd_ptr_r[s] <= rd_ptr_r[s] + PTR_W'(1);
               case ({push_s[s], grant_s[s]})
                  2'b10:   count_r[s] <= count_r[s] + CNT_W'(1);
                  2'b01:   count_r[s] <= count_r[s] - CNT_W'(1);
                  default: count_r[s] <= count_r[s];
               endcase
            end
         end
      end
   end

   // FIFO payload storage; contents are don't-care while the count says empty
   always_ff @(posedge clk) begin
      for (int s = 0; s < NB_SRC; s++) begin
         if (!rst && !flush_i && push_s[s]) begin
            mem_id_r[s][wr_ptr_r[s]]   <= src_id_i[s*ID_W +: ID_W];
            mem_we_r[s][wr_ptr_r[s]]   <= src_we_i[s];
            mem_data_r[s][wr_ptr_r[s]] <= src_data_i[s*DATA_W +: DATA_W];
         end
      end
   end

   // Registered writeback ports, loaded from the heads granted this cycle
   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         wb_valid_r <= '0;
         wb_we_r    <= '0;
         wb_id_r    <= '0;
         wb_data_r  <= '0;
      end else begin
         for (int k = 0; k < NB_WB; k++) begin
            wb_valid_r[k] <= port_vld_s[k];
            wb_we_r[k]    <= port_vld_s[k] &
                             mem_we_r[port_src_s[k]][rd_ptr_r[port_src_s[k]]];
            wb_id_r[k*ID_W +: ID_W] <= port_vld_s[k] ?
                             mem_id_r[port_src_s[k]][rd_ptr_r[port_src_s[k]]] : '0;
            wb_data_r[k*DATA_W +: DATA_W] <= port_vld_s[k] ?
                             mem_data_r[port_src_s[k]][rd_ptr_r[port_src_s[k]]] : '0;
         end
      end
   end

   assign wb_valid_o    = wb_valid_r;
   assign wb_we_o       = wb_we_r;
   assign wb_id_o       = wb_id_r;
   assign wb_data_o     = wb_data_r;
   assign compl_valid_o = wb_valid_r;
   assign compl_id_o    = wb_id_r;
   assign err_o         = err_r;

endmodule
